// File: rtl/mem_ctrl.sv
// mem_ctrl: grants the byte-wide RAM port to MEM with absolute priority and runs a 4-byte little-endian
// fetch sequencer for IF. Define MEMCTRL_PREFETCH_EN to add a one-entry next-word prefetch buffer.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_inst_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [7:0]  mem_data_i,
  output logic [7:0]  mem_data_o,
  output logic [31:0] ram_a_o,
  output logic        ram_wr_o,
  output logic [7:0]  ram_dout_o,
  input  logic [7:0]  ram_din_i
);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] faddr_q, faddr_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] inst_q, inst_d;
  logic        issue;
  logic [31:0] issue_addr;
  logic [1:0]  bsel;
  logic        demand_abort;

`ifdef MEMCTRL_PREFETCH_EN
  logic [31:0] pbuf_q, pbuf_d;
  logic [31:0] paddr_q, paddr_d;
  logic        pvalid_q, pvalid_d;
  logic        ppend_q, ppend_d;   // a prefetch of paddr is owed once the bus is free
  logic        pf_q, pf_d;         // the running FETCH is a prefetch, not a demand fetch
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      faddr_q <= '0;
      asm_q   <= '0;
      inst_q  <= '0;
`ifdef MEMCTRL_PREFETCH_EN
      pbuf_q   <= '0;
      paddr_q  <= '0;
      pvalid_q <= 1'b0;
      ppend_q  <= 1'b0;
      pf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      faddr_q <= faddr_d;
      asm_q   <= asm_d;
      inst_q  <= inst_d;
`ifdef MEMCTRL_PREFETCH_EN
      pbuf_q   <= pbuf_d;
      paddr_q  <= paddr_d;
      pvalid_q <= pvalid_d;
      ppend_q  <= ppend_d;
      pf_q     <= pf_d;
`endif
    end
  end

  // Byte 0 is issued from IDLE in the request cycle, so FETCH is entered with cnt=1 and
  // cnt always names the byte whose data is arriving plus one.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    faddr_d      = faddr_q;
    asm_d        = asm_q;
    inst_d       = inst_q;
    issue        = 1'b0;
    issue_addr   = '0;
    bsel         = cnt_q[1:0] - 2'd1;
    demand_abort = mem_req_i || !if_req_i || (if_addr_i != faddr_q);
`ifdef MEMCTRL_PREFETCH_EN
    pbuf_d   = pbuf_q;
    paddr_d  = paddr_q;
    pvalid_d = pvalid_q;
    ppend_d  = ppend_q;
    pf_d     = pf_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req_i && !mem_req_i) begin
`ifdef MEMCTRL_PREFETCH_EN
          if (pvalid_q && (if_addr_i == paddr_q)) begin
            state_d  = DONE;
            inst_d   = pbuf_q;
            faddr_d  = paddr_q;
            pvalid_d = 1'b0;
          end else begin
            state_d    = FETCH;
            cnt_d      = 3'd1;
            faddr_d    = if_addr_i;
            issue      = 1'b1;
            issue_addr = if_addr_i;
            pvalid_d   = 1'b0;
            ppend_d    = 1'b0;
            pf_d       = 1'b0;
          end
        end else if (!mem_req_i && ppend_q) begin
          state_d    = FETCH;
          cnt_d      = 3'd1;
          faddr_d    = paddr_q;
          issue      = 1'b1;
          issue_addr = paddr_q;
          pf_d       = 1'b1;
`else
          state_d    = FETCH;
          cnt_d      = 3'd1;
          faddr_d    = if_addr_i;
          issue      = 1'b1;
          issue_addr = if_addr_i;
`endif
        end
      end
      FETCH: begin
`ifdef MEMCTRL_PREFETCH_EN
        if (pf_q && (mem_req_i || if_req_i)) begin
          state_d = IDLE;
          cnt_d   = '0;
          pf_d    = 1'b0;
          if (!mem_req_i) begin
            // A demand request takes the bus from the prefetch in the same cycle.
            state_d    = FETCH;
            cnt_d      = 3'd1;
            faddr_d    = if_addr_i;
            issue      = 1'b1;
            issue_addr = if_addr_i;
            ppend_d    = 1'b0;
          end
        end else if (!pf_q && demand_abort) begin
`else
        if (demand_abort) begin
`endif
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          asm_d[{bsel, 3'b000} +: 8] = ram_din_i;
          if (cnt_q == 3'd4) begin
            cnt_d = '0;
`ifdef MEMCTRL_PREFETCH_EN
            if (pf_q) begin
              state_d  = IDLE;
              pbuf_d   = asm_d;
              pvalid_d = 1'b1;
              ppend_d  = 1'b0;
              pf_d     = 1'b0;
            end else begin
              state_d = DONE;
              inst_d  = asm_d;
            end
`else
            state_d = DONE;
            inst_d  = asm_d;
`endif
          end else begin
            cnt_d      = cnt_q + 3'd1;
            issue      = 1'b1;
            issue_addr = faddr_q + {29'd0, cnt_q};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef MEMCTRL_PREFETCH_EN
        paddr_d = faddr_q + 32'd4;
        ppend_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef MEMCTRL_PREFETCH_EN
    if (mem_req_i && mem_we_i) begin
      pvalid_d = 1'b0;
      ppend_d  = 1'b0;
    end
`endif
  end

  always_comb begin
    ram_a_o    = '0;
    ram_wr_o   = 1'b0;
    ram_dout_o = '0;
    if (mem_req_i) begin
      ram_a_o    = mem_addr_i;
      ram_wr_o   = mem_we_i;
      ram_dout_o = mem_data_i;
    end else if (issue && !rst) begin
      ram_a_o = issue_addr;
    end
  end

  assign if_done_o  = (state_q == DONE);
  assign if_inst_o  = inst_q;
  assign mem_data_o = ram_din_i;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-wide RAM model plus a reference memory image; fetch words and
// latencies are predicted from the reference image and the controller's timing rules.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_inst_o;
  logic        if_done_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_data_i;
  logic [7:0]  mem_data_o;
  logic [31:0] ram_a_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic [7:0]  ram_din_i;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_inst_o(if_inst_o), .if_done_o(if_done_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  // External RAM: 4 KiB image, synchronous write, one-cycle read latency.
  logic [7:0] ram_mem [0:4095];
  always @(posedge clk) begin
    if (ram_wr_o) ram_mem[ram_a_o[11:0]] <= ram_dout_o;
    ram_din_i <= ram_mem[ram_a_o[11:0]];
  end

`ifdef MEMCTRL_PREFETCH_EN
  localparam int PF_HIT_LAT = 1;
`else
  localparam int PF_HIT_LAT = 5;
`endif

  logic [7:0]  ref_mem [0:4095];
  logic [31:0] last_inst;
  logic [31:0] a_r;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          k, pre_at, pre_len, exp_lat;
  bit          done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = a + 32'(j);
      w[8*j +: 8] = ref_mem[b[11:0]];
    end
    return w;
  endfunction

  // One MEM write cycle through the controller; the reference image follows it.
  task automatic mem_write(input logic [31:0] a, input logic [7:0] d);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_data_i = d;
    #1;
    chk("mw_addr", ram_a_o, a);
    chk("mw_data", {24'd0, ram_dout_o}, {24'd0, d});
    chk("mw_strobe", ram_wr_o, 1'b1);
    ref_mem[a[11:0]] = d;
    tick();
    mem_req_i = 1'b0; mem_we_i = 1'b0;
  endtask

  // Demand fetch of a; MEM reads pre-empt from cycle pre_at for pre_len cycles.
  task automatic fetch(input logic [31:0] a, input int exp_lat, input int pre_at,
                       input int pre_len, input string tag);
    logic [31:0] exp_w, want_a;
    int lat, fa_err, mem_err;
    bit wr_seen;
    exp_w = model_word(a);
    lat = -1; fa_err = 0; mem_err = 0; wr_seen = 1'b0;
    if_req_i = 1'b1; if_addr_i = a;
    for (int c = 0; c < 24; c++) begin
      mem_req_i  = (c >= pre_at) && (c < pre_at + pre_len);
      mem_we_i   = 1'b0;
      mem_addr_i = 32'h0000_0800 + 32'(c);
      #1;
      if (ram_wr_o) wr_seen = 1'b1;
      if (mem_req_i && (ram_a_o !== mem_addr_i)) mem_err++;
      if (exp_lat >= 5 && c >= exp_lat - 5 && c <= exp_lat - 2) begin
        want_a = a + 32'(c - (exp_lat - 5));
        if (ram_a_o !== want_a) fa_err++;
      end
      if (if_done_o) begin
        lat = c;
        break;
      end
      tick();
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_word"}, if_inst_o, exp_w);
    chk({tag, "_no_write"}, wr_seen, 1'b0);
    chk({tag, "_mem_addr"}, mem_err, 0);
    if (exp_lat >= 5) chk({tag, "_fetch_addr"}, fa_err, 0);
    $display("fetch %s addr=%h latency=%0d inst=%h", tag, a, lat, if_inst_o);
    last_inst = exp_w;
    if_req_i = 1'b0; mem_req_i = 1'b0;
    tick();
    chk({tag, "_single_pulse"}, if_done_o, 1'b0);
  endtask

  initial begin
    rst = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h0000_1234;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_data_i = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    last_inst = '0;

    // Reset held with a pending fetch request: bus and IF outputs stay quiet.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_ram_a", ram_a_o, 32'd0);
      chk("rst_ram_wr", ram_wr_o, 1'b0);
      chk("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
      chk("rst_done", if_done_o, 1'b0);
      chk("rst_inst", if_inst_o, 32'd0);
    end
    if_req_i = 1'b0; rst = 1'b0;
    tick();

    // Program image via MEM writes, then the basic 5-cycle fetch.
    mem_write(32'h100, 8'h13); mem_write(32'h101, 8'h05);
    mem_write(32'h102, 8'h00); mem_write(32'h103, 8'h00);
    mem_write(32'h104, 8'h93); mem_write(32'h105, 8'h05);
    mem_write(32'h106, 8'h10); mem_write(32'h107, 8'h00);
    fetch(32'h100, 5, 99, 0, "basic");
    chk("basic_literal", if_inst_o, 32'h0000_0513);

    // MEM word store as four byte cycles, then a read-back through mem_data_o.
    mem_write(32'h200, 8'hEF); mem_write(32'h201, 8'hBE);
    mem_write(32'h202, 8'hAD); mem_write(32'h203, 8'hDE);
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h201;
    tick();
    chk("mem_readback", {24'd0, mem_data_o}, 32'h0000_00BE);
    mem_req_i = 1'b0;
    tick();

    // MEM pre-empts in cycles 2-4; fetch restarts in cycle 5, done in cycle 10.
    fetch(32'h100, 10, 2, 3, "preempt");

    // Flush: request dropped in cycle 3.
    if_req_i = 1'b1; if_addr_i = 32'h104; done_seen = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if_req_i = (c < 3);
      #1;
      if (if_done_o) done_seen = 1'b1;
      if (c == 4) chk("flush_bus_idle", ram_a_o, 32'd0);
      tick();
    end
    chk("flush_no_done", done_seen, 1'b0);
    chk("flush_inst_held", if_inst_o, last_inst);
    $display("flush addr=00000104 done_seen=%0d", done_seen);

    // Reset in cycle 2 of a fetch.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_bus_quiet", ram_a_o, 32'd0);
    tick();
    rst = 1'b0;
    chk("midrst_done", if_done_o, 1'b0);
    chk("midrst_inst", if_inst_o, 32'd0);
    last_inst = '0;
    fetch(32'h100, 5, 99, 0, "after_rst");

    // Sequential request after an idle gap (prefetch hit when the buffer is built in).
    fetch(32'h100, 5, 99, 0, "pf_base");
    repeat (6) tick();
    fetch(32'h104, PF_HIT_LAT, 99, 0, "pf_next");

    // A MEM write in the idle gap invalidates any prefetched word.
    fetch(32'h100, 5, 99, 0, "pfw_base");
    k = $urandom_range(0, 5);
    for (int g = 0; g < 6; g++) begin
      if (g == k) mem_write(32'h380 + 32'(g), 8'($urandom));
      else tick();
    end
    fetch(32'h104, 5, 99, 0, "pfw_next");

    // Random words, random addresses (one wrapping past 2^32), random MEM pre-emption.
    for (int i = 0; i < 16; i++) begin
      a_r = (i == 7) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 4095));
      for (int j = 0; j < 4; j++) mem_write(a_r + 32'(j), 8'($urandom));
      pre_at  = $urandom_range(0, 7);
      pre_len = $urandom_range(1, 3);
      exp_lat = (pre_at <= 4) ? pre_at + pre_len + 5 : 5;
      fetch(a_r, exp_lat, pre_at, pre_len, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
